// File: rtl/memory_bank.sv
// Program/data memory for the CPU: switch loading (IN), program stepping (CHECK)
// and a registered one-cycle read/write port with program write-protection (RUN).
module memory_bank #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int PROG_DEPTH = 32,
  parameter int RAM_DEPTH  = 256,
  parameter int DEBOUNCE   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    cpustate,
  input  logic                          key_n,
  input  logic [DATA_W-1:0]             sw_in,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          read,
  input  logic                          write,
  output logic [DATA_W-1:0]             data_out,
  output logic                          ack,
  output logic                          err,
  output logic [DATA_W-1:0]             check_out,
  output logic [$clog2(PROG_DEPTH)-1:0] ptr_out,
  output logic                          load_full
);

  localparam int PTR_W  = $clog2(PROG_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int CNT_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(PROG_DEPTH - 1);
  localparam logic [ADDR_W:0]   PROG_END = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W:0]   RAM_END  = (ADDR_W+1)'(PROG_DEPTH + RAM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IN    = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } cpu_state_e;

  logic [DATA_W-1:0] prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] ram_mem  [RAM_DEPTH];

  logic             key_s1_q, key_s2_q;
  logic             key_armed_q, key_armed_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic             press_q, press_d;

  logic [1:0]        prev_state_q;
  logic [PTR_W-1:0]  load_ptr_q, load_ptr_d;
  logic              load_full_q, load_full_d;
  logic [PTR_W-1:0]  check_ptr_q, check_ptr_d;
  logic [PTR_W-1:0]  ptr_out_q, ptr_out_d;
  logic [DATA_W-1:0] check_out_q, check_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              enter_in, enter_check, in_prog, in_ram, run_req, prog_we, ram_we;
  logic [ADDR_W:0]   addr_ext;
  logic [RAM_AW-1:0] ram_idx;
  logic [PTR_W-1:0]  check_idx;

  // key_armed_q=1: released level confirmed, waiting for a held low.
  // key_armed_q=0 (also after reset): waiting for a held high, so a key held
  // through reset must be released before it can count again.
  always_comb begin
    key_armed_d = key_armed_q;
    key_cnt_d   = '0;
    press_d     = 1'b0;
    if (key_s2_q != key_armed_q) begin
      if (key_cnt_q == CNT_MAX) begin
        key_armed_d = ~key_armed_q;
        press_d     = key_armed_q;
      end else begin
        key_cnt_d = key_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    enter_in    = (cpustate == ST_IN)    && (prev_state_q != ST_IN);
    enter_check = (cpustate == ST_CHECK) && (prev_state_q != ST_CHECK);
    addr_ext    = {1'b0, addr};
    in_prog     = addr_ext < PROG_END;
    in_ram      = !in_prog && (addr_ext < RAM_END);
    ram_idx     = RAM_AW'(addr_ext - PROG_END);
    run_req     = (cpustate == ST_RUN) && (read || write);
    prog_we     = press_q && (cpustate == ST_IN) && !enter_in && !load_full_q && !reset;
    ram_we      = (cpustate == ST_RUN) && write && in_ram && !reset;
    check_idx   = enter_check ? '0 : check_ptr_q;

    load_ptr_d  = load_ptr_q;
    load_full_d = load_full_q;
    if (enter_in) begin
      load_ptr_d  = '0;
      load_full_d = 1'b0;
    end else if (prog_we) begin
      if (load_ptr_q == PTR_LAST) load_full_d = 1'b1;
      else                        load_ptr_d  = load_ptr_q + 1'b1;
    end

    check_ptr_d = check_ptr_q;
    if (enter_check) begin
      check_ptr_d = '0;
    end else if (press_q && (cpustate == ST_CHECK)) begin
      check_ptr_d = (check_ptr_q == PTR_LAST) ? '0 : check_ptr_q + 1'b1;
    end

    ptr_out_d   = '0;
    check_out_d = '0;
    if (cpustate == ST_IN) begin
      ptr_out_d = enter_in ? '0 : load_ptr_q;
    end else if (cpustate == ST_CHECK) begin
      ptr_out_d   = check_idx;
      check_out_d = prog_mem[check_idx];
    end

    // Read data is taken before this cycle's write lands (read-before-write).
    data_out_d = data_out_q;
    if ((cpustate == ST_RUN) && read) begin
      if (in_prog)     data_out_d = prog_mem[addr[PTR_W-1:0]];
      else if (in_ram) data_out_d = ram_mem[ram_idx];
      else             data_out_d = '0;
    end
    ack_d = run_req;
    err_d = run_req && ((write && !in_ram) || (read && !in_prog && !in_ram));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q     <= 1'b1;
      key_s2_q     <= 1'b1;
      key_armed_q  <= 1'b0;
      key_cnt_q    <= '0;
      press_q      <= 1'b0;
      prev_state_q <= ST_IDLE;
      load_ptr_q   <= '0;
      load_full_q  <= 1'b0;
      check_ptr_q  <= '0;
      ptr_out_q    <= '0;
      check_out_q  <= '0;
      data_out_q   <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      key_s1_q     <= key_n;
      key_s2_q     <= key_s1_q;
      key_armed_q  <= key_armed_d;
      key_cnt_q    <= key_cnt_d;
      press_q      <= press_d;
      prev_state_q <= cpustate;
      load_ptr_q   <= load_ptr_d;
      load_full_q  <= load_full_d;
      check_ptr_q  <= check_ptr_d;
      ptr_out_q    <= ptr_out_d;
      check_out_q  <= check_out_d;
      data_out_q   <= data_out_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  // Contents survive reset; write enables are already gated by reset.
  always_ff @(posedge clk) begin
    if (prog_we) prog_mem[load_ptr_q] <= sw_in;
    if (ram_we)  ram_mem[ram_idx]     <= data_in;
  end

  assign data_out  = data_out_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign check_out = check_out_q;
  assign ptr_out   = ptr_out_q;
  assign load_full = load_full_q;

endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank: reset, IN loading, CHECK stepping, debounce,
// fill/wrap, RUN RAM access, protection and range errors.
module tb_memory_bank;

  localparam int DEB = 4;

  logic       clk;
  logic       reset;
  logic [1:0] cpustate;
  logic       key_n;
  logic [7:0] sw_in;
  logic [15:0] addr;
  logic [7:0] data_in;
  logic       read;
  logic       write;
  logic [7:0] data_out;
  logic       ack;
  logic       err;
  logic [7:0] check_out;
  logic [4:0] ptr_out;
  logic       load_full;

  int n_checks = 0;
  int n_errors = 0;

  memory_bank #(
    .DATA_W(8), .ADDR_W(16), .PROG_DEPTH(32), .RAM_DEPTH(256), .DEBOUNCE(DEB)
  ) dut (
    .clk(clk), .reset(reset), .cpustate(cpustate), .key_n(key_n), .sw_in(sw_in),
    .addr(addr), .data_in(data_in), .read(read), .write(write),
    .data_out(data_out), .ack(ack), .err(err), .check_out(check_out),
    .ptr_out(ptr_out), .load_full(load_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the key long enough to register, then release long enough to re-arm.
  task automatic press(input logic [7:0] val);
    sw_in = val;
    key_n = 1'b0;
    cycles(DEB + 6);
    key_n = 1'b1;
    cycles(DEB + 8);
  endtask

  // One RUN request cycle; outputs are valid at the following negedge.
  task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    read = r; write = w; addr = a; data_in = d;
    cycles(1);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic set_state(input logic [1:0] s);
    cpustate = s;
    cycles(2);
  endtask

  initial begin
    reset = 1'b1; cpustate = 2'b11; key_n = 1'b1; sw_in = 8'h00;
    addr = 16'h0200; data_in = 8'hFF; read = 1'b1; write = 1'b0;

    // Reset with a live RUN read request
    cycles(3);
    check_val("rst_data_out", data_out, 8'h00);
    check_val("rst_ack", ack, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_check_out", check_out, 8'h00);
    check_val("rst_ptr_out", ptr_out, 5'd0);
    check_val("rst_load_full", load_full, 1'b0);
    reset = 1'b0;
    cycles(1);
    check_val("first_ack", ack, 1'b1);
    check_val("first_err_range", err, 1'b1);
    check_val("first_data_range", data_out, 8'h00);
    read = 1'b0;
    cycles(10);

    // IN load with exact key latency on the first press
    set_state(2'b01);
    sw_in = 8'h11; key_n = 1'b0;
    cycles(7);
    check_val("lat_ptr_before", ptr_out, 5'd0);
    cycles(1);
    check_val("lat_ptr_after", ptr_out, 5'd1);
    cycles(2);
    key_n = 1'b1;
    cycles(DEB + 8);
    press(8'h22);
    check_val("in_ptr_2", ptr_out, 5'd2);
    press(8'h33);
    check_val("in_ptr_3", ptr_out, 5'd3);
    check_val("in_not_full", load_full, 1'b0);

    // CHECK stepping
    set_state(2'b10);
    check_val("chk_word0", check_out, 8'h11);
    check_val("chk_ptr0", ptr_out, 5'd0);
    press(8'h00);
    check_val("chk_word1", check_out, 8'h22);
    check_val("chk_ptr1", ptr_out, 5'd1);
    press(8'h00);
    check_val("chk_word2", check_out, 8'h33);

    // Debounce: short glitch ignored, long hold counts once
    set_state(2'b00);
    set_state(2'b01);
    check_val("in_reentry_ptr", ptr_out, 5'd0);
    sw_in = 8'hBB; key_n = 1'b0;
    cycles(DEB - 1);
    key_n = 1'b1;
    cycles(15);
    check_val("glitch_no_write", ptr_out, 5'd0);
    sw_in = 8'h44; key_n = 1'b0;
    cycles(100);
    key_n = 1'b1;
    cycles(15);
    check_val("long_hold_one_write", ptr_out, 5'd1);
    set_state(2'b10);
    check_val("long_hold_word", check_out, 8'h44);

    // Fill all 32 slots, then one extra press
    set_state(2'b00);
    set_state(2'b01);
    for (int i = 0; i < 32; i++) press(8'h80 + 8'(i));
    check_val("fill_full", load_full, 1'b1);
    check_val("fill_ptr", ptr_out, 5'd31);
    press(8'hEE);
    check_val("fill_extra_ptr", ptr_out, 5'd31);
    check_val("fill_extra_full", load_full, 1'b1);

    // CHECK wrap over all 32 slots
    set_state(2'b10);
    check_val("wrap_start", check_out, 8'h80);
    for (int i = 0; i < 31; i++) press(8'h00);
    check_val("wrap_ptr31", ptr_out, 5'd31);
    check_val("wrap_last_kept", check_out, 8'h9F);
    press(8'h00);
    check_val("wrap_ptr0", ptr_out, 5'd0);
    check_val("wrap_word0", check_out, 8'h80);

    // RUN: RAM write/read, read-before-write
    set_state(2'b11);
    access(1'b0, 1'b1, 16'h0020, 8'hA5);
    check_val("wr_ack", ack, 1'b1);
    check_val("wr_err", err, 1'b0);
    access(1'b1, 1'b0, 16'h0020, 8'h00);
    check_val("rd_data", data_out, 8'hA5);
    check_val("rd_ack", ack, 1'b1);
    check_val("rd_err", err, 1'b0);
    cycles(1);
    check_val("ack_one_cycle", ack, 1'b0);
    access(1'b1, 1'b1, 16'h0020, 8'h5A);
    check_val("rbw_old_data", data_out, 8'hA5);
    check_val("rbw_ack", ack, 1'b1);
    access(1'b1, 1'b0, 16'h0020, 8'h00);
    check_val("rbw_new_data", data_out, 8'h5A);

    // Protection and range
    access(1'b0, 1'b1, 16'h0003, 8'h77);
    check_val("prot_err", err, 1'b1);
    check_val("prot_ack", ack, 1'b1);
    access(1'b1, 1'b0, 16'h0003, 8'h00);
    check_val("prot_unchanged", data_out, 8'h83);
    check_val("prog_rd_err", err, 1'b0);
    access(1'b1, 1'b0, 16'h001F, 8'h00);
    check_val("prog31_kept", data_out, 8'h9F);
    access(1'b1, 1'b0, 16'h0120, 8'h00);
    check_val("range_data", data_out, 8'h00);
    check_val("range_err", err, 1'b1);
    access(1'b0, 1'b1, 16'h011F, 8'h3C);
    check_val("ram_top_wr_err", err, 1'b0);

    // Back-to-back reads, one ack per cycle
    read = 1'b1; addr = 16'h0020;
    cycles(1);
    check_val("b2b_data0", data_out, 8'h5A);
    check_val("b2b_ack0", ack, 1'b1);
    addr = 16'h011F;
    cycles(1);
    check_val("b2b_data1", data_out, 8'h3C);
    check_val("b2b_ack1", ack, 1'b1);

    // Requests outside RUN are ignored; data_out holds
    cpustate = 2'b00;
    cycles(2);
    check_val("idle_ack", ack, 1'b0);
    check_val("idle_err", err, 1'b0);
    check_val("idle_hold", data_out, 8'h3C);
    read = 1'b0;

    // Reset in the middle of an IN press
    set_state(2'b01);
    sw_in = 8'hDD; key_n = 1'b0;
    cycles(4);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(20);
    check_val("rst_press_ptr", ptr_out, 5'd0);
    check_val("rst_press_full", load_full, 1'b0);
    key_n = 1'b1;
    cycles(15);
    check_val("rst_press_ptr_rel", ptr_out, 5'd0);
    set_state(2'b10);
    check_val("rst_press_no_write", check_out, 8'h80);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
